reg_dump_reader: RTL
====================

# reg_dump_reader

Sequential read-out engine for the register file: on a start request it walks every register address from 0 to 2**R_SIZE−1, samples the register file's asynchronous source port, and presents each value on a valid/ready stream. It sits beside the CPU datapath and owns the register file's `sAddressIn` only while `busy` is high; the top level muxes it in. Typical consumers are a debug UART or an LED/switch display stepper.

## Interface
Parameters:
- `N`, default `cpuConfig::N`: register data width.
- `R_SIZE`, default `cpuConfig::R_SIZE`: register address width; the register count is 2**R_SIZE.

Ports:
- `clk`, input, 1: the only clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a dump. Sampled only in IDLE.
- `rdAddressOut`, output, R_SIZE: address driven to the register file `sAddressIn`.
- `rdDataIn`, input, N: the register file `sOut`, which is combinational in `rdAddressOut`.
- `dumpData`, output, N: the captured register value.
- `dumpAddr`, output, R_SIZE: the address of `dumpData`.
- `dumpValid`, output, 1: `dumpData`/`dumpAddr` are valid.
- `dumpReady`, input, 1: the consumer accepts the data.
- `busy`, output, 1: a dump is in progress. The top level gives this block the read port while `busy` is high.
- `haltReq`, output, 1: equal to `busy`. Asks the CPU to stall register writes so the snapshot stays consistent.
- `done`, output, 1: a one-cycle pulse after the last beat is accepted.

## Operation
- The FSM has four states: IDLE, SETUP, PRESENT, DONE.
- **IDLE:**
  - `busy`=0, `dumpValid`=0.
  - If `start`=1: `addr`←0, go to SETUP.
- **SETUP:**
  - `rdAddressOut`=`addr`, held for one full cycle so the asynchronous read settles.
  - At the end of this cycle: `dumpData`←`rdDataIn`, `dumpAddr`←`addr`, go to PRESENT.
- **PRESENT:**
  - `dumpValid`=1.
  - On a cycle with `dumpValid`&&`dumpReady`, the beat is transferred:
    - if `addr`==2**R_SIZE−1, go to DONE;
    - otherwise `addr`←`addr`+1 and go to SETUP.
  - Otherwise hold. `dumpData` and `dumpAddr` must stay stable until the transfer, and `dumpValid` never drops without a transfer.
- **DONE:**
  - `done`=1 for exactly one cycle, then go to IDLE.
- **Output decode:**
  - `busy`=1 in SETUP, PRESENT and DONE.
  - `rdAddressOut`=`addr` in every state, and `addr` is 0 in IDLE.
- **Address arithmetic:**
  - `addr` is an R_SIZE-bit unsigned value.
  - The last-address compare is against all-ones.
  - `addr` never wraps, because the increment is suppressed at the last address.
- **Data handling:** `dumpData` is a raw bit copy with no sign handling. For example, −23 with N=8 is emitted as 8'hE9.
- **Boundary rules:**
  - `start` while `busy`: ignored. No restart and no queueing.
  - `start` held high continuously: a new dump begins the cycle after DONE returns to IDLE.
  - `dumpReady` high before `dumpValid`: allowed; the transfer happens on the first PRESENT cycle.
  - `reset` mid-dump: the next state is IDLE, all outputs take their reset values, and the partial beat is discarded.
  - R_SIZE=1: a two-beat dump, with no other change in behaviour.

## Timing
- **Reset values:**
  - FSM: IDLE.
  - Internal `addr`: 0.
  - Outputs: `rdAddressOut`=0, `dumpData`=0, `dumpAddr`=0, `dumpValid`=0, `busy`=0, `haltReq`=0, `done`=0.
- **Start latency:** with `start` sampled at edge k:
  - `busy`=1 after edge k;
  - `dumpValid`=1 with register 0 after edge k+1.
- **Beat timing:**
  - Each beat costs 2 cycles minimum (SETUP + PRESENT) with `dumpReady` tied high.
  - A full dump takes 2·2**R_SIZE + 1 cycles from the first `busy` cycle to the last `done` cycle. For R_SIZE=2 that is 9 cycles.
- **Snapshot rule:** the captured value is `rdDataIn` at the edge leaving SETUP. A register file write landing on that same edge is not seen; a write on the edge into SETUP is seen.
- **`done` pulse:** asserted in the cycle after the last handshake edge.

## Structure
- `cpuConfig` already provides N and R_SIZE. Add to it:
  - the typedef `dumpState_t` enum {IDLE, SETUP, PRESENT, DONE};
  - the constant `R_COUNT = 2**R_SIZE`.
- The block is a single module with no sub-module. The FSM and the capture registers are small enough to keep flat.
- The bench instantiates the real `registers` module and wires `rdAddressOut`→`sAddressIn` and `sOut`→`rdDataIn`.

## Test plan
- **Reset:** preload regs = {0, 5, −23, 8'h7F}, N=8, R_SIZE=2. Hold `reset` for 2 cycles, then release → all outputs are 0 and the FSM is in IDLE.
- **Full-rate dump:** `dumpReady`=1, `start` pulse at edge k → `dumpValid` first high after k+1. Beats are (0,8'h00), (1,8'h05), (2,8'hE9), (3,8'h7F), with `dumpValid` high every other cycle. `done` is high exactly 1 cycle, 9 cycles after `busy` rose.
- **Back-pressure:** `dumpReady` held low for 5 cycles during beat 2 → `dumpValid` stays high, `dumpData`=8'hE9 and `dumpAddr`=2 are stable throughout, and `addr` does not advance.
- **`start` while busy:** a second `start` pulse during beat 1 → it is ignored. Exactly 4 beats and one `done` pulse are produced.
- **Reset mid-dump:** `reset` asserted while presenting beat 2 → the next cycle has `busy`=0, `dumpValid`=0 and `rdAddressOut`=0. A later `start` dumps from address 0.
- **Write on the capture edge:** the CPU writes 8'h11 to reg 1 on the SETUP-exit edge of beat 1 → the beat reports 8'h05. A write one cycle earlier → the beat reports 8'h11.

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// Shared configuration and state encoding for the register-file dump reader.
package reg_dump_reader_pkg;

  localparam int N       = 8;
  localparam int R_SIZE  = 2;
  localparam int R_COUNT = 2 ** R_SIZE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } dumpState_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks every register address, samples the async read port one settle cycle
// after driving the address, and streams (addr, data) beats over valid/ready.
module reg_dump_reader #(
  parameter int N      = reg_dump_reader_pkg::N,
  parameter int R_SIZE = reg_dump_reader_pkg::R_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [R_SIZE-1:0] rdAddressOut,
  input  logic [N-1:0]      rdDataIn,
  output logic [N-1:0]      dumpData,
  output logic [R_SIZE-1:0] dumpAddr,
  output logic              dumpValid,
  input  logic              dumpReady,
  output logic              busy,
  output logic              haltReq,
  output logic              done
);

  import reg_dump_reader_pkg::*;

  localparam logic [R_SIZE-1:0] LAST_ADDR = {R_SIZE{1'b1}};

  dumpState_t        state_q, state_d;
  logic [R_SIZE-1:0] addr_q, addr_d;
  logic [N-1:0]      data_q, data_d;
  logic [R_SIZE-1:0] daddr_q, daddr_d;

  // State and capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= {R_SIZE{1'b0}};
      data_q  <= {N{1'b0}};
      daddr_q <= {R_SIZE{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    daddr_d = daddr_q;
    case (state_q)
      IDLE: begin
        addr_d = {R_SIZE{1'b0}};
        if (start) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        // Address has been stable for a full cycle, so the async read has settled.
        data_d  = rdDataIn;
        daddr_d = addr_q;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (dumpReady) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + R_SIZE'(1);
            state_d = SETUP;
          end
        end else begin
          state_d = PRESENT;
        end
      end
      DONE: begin
        addr_d  = {R_SIZE{1'b0}};
        state_d = IDLE;
      end
      default: begin
        addr_d  = {R_SIZE{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    busy      = 1'b0;
    dumpValid = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      SETUP: begin
        busy = 1'b1;
      end
      PRESENT: begin
        busy      = 1'b1;
        dumpValid = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign haltReq      = busy;
  assign rdAddressOut = addr_q;
  assign dumpData     = data_q;
  assign dumpAddr     = daddr_q;

endmodule
